fpu_div_frac_iter: RTL

Parametrised, self-sequencing fraction divider for the FPU divide pipe. It replaces externally stepped add/shift control with an internal restoring-division state machine, using a start/busy/done handshake. It supports a full-width (double) mode and a reduced-width (single) mode with early completion, plus a sticky output and a kill input. It sits after operand normalisation; exponent, rounding and special-case handling stay outside the block.

---
 rtl/fpu_div_frac_iter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fpu_div_frac_iter.sv
// Self-sequencing restoring fraction divider for the FPU divide pipe.
//
// A start request accepted in idle latches normalised dividend and divisor
// fractions and runs one restoring-division step per clock. The result is
// registered and flagged by a single-cycle done pulse.
//
// Ports:
//   rclk      clock, all state updates on the rising edge
//   reset     synchronous, active-high reset
//   start     request, sampled only while idle
//   dblop     1 = double mode (Q_W steps), 0 = single mode (SNG_W+2 steps)
//   kill      abort an in-flight divide; overrides start while idle
//   frac_in1  dividend fraction, normalised (MSB = 1)
//   frac_in2  divisor fraction, normalised (MSB = 1)
//   busy      high while iterating
//   done      one-cycle pulse when quo/sticky are valid
//   quo       quotient, quo[Q_W-1] has weight 1.0
//   sticky    final partial remainder is non-zero
//   div_zero  divisor was zero when the request was accepted
module fpu_div_frac_iter #(
    parameter int unsigned FRAC_W = 53,
    parameter int unsigned SNG_W  = 24,
    parameter int unsigned Q_W    = FRAC_W + 2,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              rclk,
    input  logic              reset,
    input  logic              start,
    input  logic              dblop,
    input  logic              kill,
    input  logic [FRAC_W-1:0] frac_in1,
    input  logic [FRAC_W-1:0] frac_in2,
    output logic              busy,
    output logic              done,
    output logic [Q_W-1:0]    quo,
    output logic              sticky,
    output logic              div_zero
);

    localparam int unsigned REM_W = FRAC_W + 2;
    localparam int unsigned PAD_W = FRAC_W - SNG_W;
    localparam logic [CNT_W-1:0] CNT_DBL = CNT_W'(Q_W - 1);
    localparam logic [CNT_W-1:0] CNT_SNG = CNT_W'(SNG_W + 1);
    // Keeps the SNG_W most significant fraction bits in single mode.
    localparam logic [FRAC_W-1:0] SNG_MASK = ~({FRAC_W{1'b1}} >> SNG_W);

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

    state_e            state_q, state_d;
    logic              dbl_q, dbl_d;
    logic              dvd_nz_q, dvd_nz_d;
    logic [FRAC_W-1:0] dsr_q, dsr_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [Q_W-1:0]    q_q, q_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [Q_W-1:0]    quo_q, quo_d;
    logic              sticky_q, sticky_d;
    logic              div_zero_q, div_zero_d;
    logic              done_q, done_d;

    logic [FRAC_W-1:0] dvd_in, dsr_in;
    logic [REM_W:0]    diff_ext;
    logic              diff_ge;

    assign dvd_in = dblop ? frac_in1 : (frac_in1 & SNG_MASK);
    assign dsr_in = dblop ? frac_in2 : (frac_in2 & SNG_MASK);

    // One extra bit makes the compare unsigned, so a zero divisor always
    // yields a quotient bit of 1 even once the remainder's MSB is set.
    assign diff_ext = {1'b0, rem_q} - {3'b000, dsr_q};
    assign diff_ge  = ~diff_ext[REM_W];

    always_comb begin
        state_d    = state_q;
        dbl_d      = dbl_q;
        dvd_nz_d   = dvd_nz_q;
        dsr_d      = dsr_q;
        rem_d      = rem_q;
        q_d        = q_q;
        cnt_d      = cnt_q;
        quo_d      = quo_q;
        sticky_d   = sticky_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !kill) begin
                    dbl_d      = dblop;
                    dsr_d      = dsr_in;
                    dvd_nz_d   = |dvd_in;
                    rem_d      = {2'b00, dvd_in};
                    q_d        = '0;
                    cnt_d      = dblop ? CNT_DBL : CNT_SNG;
                    div_zero_d = (dsr_in == '0);
                    state_d    = StIter;
                end
            end
            StIter: begin
                if (kill) begin
                    state_d = StIdle;
                end else begin
                    rem_d = diff_ge ? (diff_ext[REM_W-1:0] << 1) : (rem_q << 1);
                    q_d   = {q_q[Q_W-2:0], diff_ge};
                    if (cnt_q == '0) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                if (!kill) begin
                    done_d   = 1'b1;
                    quo_d    = dbl_q ? q_q : {q_q[SNG_W+1:0], {PAD_W{1'b0}}};
                    // With a zero divisor the dividend is shifted out of the
                    // remainder, so report whether there was anything to divide.
                    sticky_d = div_zero_q ? dvd_nz_q : |rem_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            state_q    <= StIdle;
            dbl_q      <= 1'b0;
            dvd_nz_q   <= 1'b0;
            dsr_q      <= '0;
            rem_q      <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            quo_q      <= '0;
            sticky_q   <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dbl_q      <= dbl_d;
            dvd_nz_q   <= dvd_nz_d;
            dsr_q      <= dsr_d;
            rem_q      <= rem_d;
            q_q        <= q_d;
            cnt_q      <= cnt_d;
            quo_q      <= quo_d;
            sticky_q   <= sticky_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == StIter);
    assign done     = done_q;
    assign quo      = quo_q;
    assign sticky   = sticky_q;
    assign div_zero = div_zero_q;

endmodule
